// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC, the next-fetch mux and the trap-return
// state (epc/mcause), including misaligned-target trap detection.
module pc_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned CAUSE_W      = 5,
  parameter bit          VECTORED     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic               j_en,
  input  logic [XLEN-1:0]    addr_from_alu,
  input  logic               trap_req,
  input  logic               trap_irq,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic               mret,
  input  logic [XLEN-1:0]    mtvec_base,
  input  logic               csr_epc_we,
  input  logic [XLEN-1:0]    csr_epc_wdata,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    next_pc,
  output logic [XLEN-1:0]    epc,
  output logic [XLEN-1:0]    mcause,
  output logic               flush,
  output logic               trap_taken
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic            redirect, mis, hold_sel;
  logic [XLEN-1:0] pc_plus4, tvec_base, tvec, fallthru;

  assign redirect  = br_taken | j_en;
  assign mis       = redirect & (addr_from_alu[1:0] != 2'b00) & ~stall;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign tvec_base = {mtvec_base[XLEN-1:2], 2'b00};

  always_comb begin
    tvec = tvec_base;
    if (VECTORED && trap_irq)
      tvec = tvec_base + (XLEN'(trap_cause) << 2);
  end

  // Address the non-trap path would fetch; also the resume point for interrupts.
  always_comb begin
    fallthru = pc_plus4;
    if (stall)         fallthru = pc_q;
    else if (mret)     fallthru = epc_q;
    else if (redirect) fallthru = addr_from_alu;
  end

  always_comb begin
    pc_d       = fallthru;
    epc_d      = epc_q;
    mcause_d   = mcause_q;
    trap_taken = 1'b0;
    if (rst) begin
      pc_d     = RESET_VECTOR;
      epc_d    = '0;
      mcause_d = '0;
    end else if (trap_req) begin
      trap_taken = 1'b1;
      pc_d       = tvec;
      epc_d      = trap_irq ? {fallthru[XLEN-1:2], 2'b00} : {pc_q[XLEN-1:2], 2'b00};
      mcause_d   = {trap_irq, {(XLEN-1-CAUSE_W){1'b0}}, trap_cause};
    end else if (mis) begin
      trap_taken = 1'b1;
      pc_d       = tvec_base;
      epc_d      = {pc_q[XLEN-1:2], 2'b00};
      mcause_d   = '0;
    end else if (csr_epc_we) begin
      epc_d = {csr_epc_wdata[XLEN-1:2], 2'b00};
    end
  end

  // A plain stall is the only non-sequential next PC that is not a flush.
  assign hold_sel = stall & ~trap_req;
  assign flush    = ~rst & ~hold_sel & (pc_d != pc_plus4);
  assign next_pc  = pc_d;

  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    epc_q    <= epc_d;
    mcause_q <= mcause_d;
  end

  assign pc_out = pc_q;
  assign epc    = epc_q;
  assign mcause = mcause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (vectored build, reset vector 0x100).
module tb_pc_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, stall, br_taken, j_en, trap_req, trap_irq, mret, csr_epc_we;
  logic [4:0]      trap_cause;
  logic [XLEN-1:0] addr_from_alu, mtvec_base, csr_epc_wdata;
  logic [XLEN-1:0] pc_out, next_pc, epc, mcause;
  logic            flush, trap_taken;

  int n_vec = 0;
  int n_bad = 0;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h100), .CAUSE_W(5), .VECTORED(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .j_en(j_en),
    .addr_from_alu(addr_from_alu), .trap_req(trap_req), .trap_irq(trap_irq),
    .trap_cause(trap_cause), .mret(mret), .mtvec_base(mtvec_base),
    .csr_epc_we(csr_epc_we), .csr_epc_wdata(csr_epc_wdata), .pc_out(pc_out),
    .next_pc(next_pc), .epc(epc), .mcause(mcause), .flush(flush), .trap_taken(trap_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; br_taken = 0; j_en = 0; trap_req = 0; trap_irq = 0;
    mret = 0; csr_epc_we = 0; trap_cause = '0; addr_from_alu = '0; csr_epc_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic jump_to(input logic [XLEN-1:0] a);
    idle(); j_en = 1; addr_from_alu = a;
    step(); idle();
  endtask

  initial begin
    idle(); mtvec_base = 32'h800;
    // Reset with noise on other inputs: everything ignored.
    rst = 1; trap_req = 1; j_en = 1; addr_from_alu = 32'h42; csr_epc_we = 1; csr_epc_wdata = 32'h55;
    #1;
    chk("rst_next_pc", next_pc, 32'h100);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_trap_taken", {31'b0, trap_taken}, 32'h0);
    step(); step();
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_epc", epc, 32'h0);
    chk("rst_mcause", mcause, 32'h0);
    idle(); #1;
    chk("seq_flush", {31'b0, flush}, 32'h0);
    chk("seq_next", next_pc, 32'h104);
    step(); chk("seq_pc104", pc_out, 32'h104);
    step(); chk("seq_pc108", pc_out, 32'h108);

    // Stall with a pending branch, then release.
    jump_to(32'h200);
    chk("jmp_pc200", pc_out, 32'h200);
    for (int i = 0; i < 3; i++) begin
      stall = 1; br_taken = 1; addr_from_alu = 32'h300; #1;
      chk("stall_flush", {31'b0, flush}, 32'h0);
      chk("stall_next", next_pc, 32'h200);
      step();
      chk("stall_pc", pc_out, 32'h200);
    end
    stall = 0; #1;
    chk("release_flush", {31'b0, flush}, 32'h1);
    chk("release_next", next_pc, 32'h300);
    step(); chk("release_pc", pc_out, 32'h300);

    // Vectored interrupt on a jump: epc gets the jump target.
    jump_to(32'h400);
    mtvec_base = 32'h1001; trap_req = 1; trap_irq = 1; trap_cause = 5'd7;
    j_en = 1; addr_from_alu = 32'h500; #1;
    chk("virq_next", next_pc, 32'h101C);
    chk("virq_taken", {31'b0, trap_taken}, 32'h1);
    chk("virq_flush", {31'b0, flush}, 32'h1);
    step();
    chk("virq_pc", pc_out, 32'h101C);
    chk("virq_epc", epc, 32'h500);
    chk("virq_mcause", mcause, 32'h8000_0007);

    // Misaligned jump target.
    idle(); mtvec_base = 32'h800;
    jump_to(32'h40);
    j_en = 1; addr_from_alu = 32'h42; #1;
    chk("mis_taken", {31'b0, trap_taken}, 32'h1);
    chk("mis_next", next_pc, 32'h800);
    step();
    chk("mis_pc", pc_out, 32'h800);
    chk("mis_epc", epc, 32'h40);
    chk("mis_mcause", mcause, 32'h0);

    // Misaligned target under stall is not a trap.
    idle(); stall = 1; j_en = 1; addr_from_alu = 32'h42; #1;
    chk("mis_stall_taken", {31'b0, trap_taken}, 32'h0);
    chk("mis_stall_next", next_pc, 32'h800);

    // Trap and CSR write collide: trap capture wins; mret returns there.
    jump_to(32'h60);
    trap_req = 1; trap_cause = 5'd2; csr_epc_we = 1; csr_epc_wdata = 32'h999;
    step();
    chk("coll_pc", pc_out, 32'h800);
    chk("coll_epc", epc, 32'h60);
    chk("coll_mcause", mcause, 32'h2);
    idle(); stall = 1; mret = 1; #1;
    chk("mret_stall_next", next_pc, 32'h800);
    stall = 0; #1;
    chk("mret_next", next_pc, 32'h60);
    chk("mret_flush", {31'b0, flush}, 32'h1);
    step();
    chk("mret_pc", pc_out, 32'h60);
    chk("mret_epc_kept", epc, 32'h60);
    chk("mret_mcause_kept", mcause, 32'h2);

    // CSR write masks low bits; interrupt during mret saves the old epc.
    idle(); csr_epc_we = 1; csr_epc_wdata = 32'h1237;
    step(); chk("csr_epc", epc, 32'h1234);
    idle(); mret = 1; trap_req = 1; trap_irq = 1; trap_cause = 5'd3;
    step();
    chk("irq_mret_pc", pc_out, 32'h80C);
    chk("irq_mret_epc", epc, 32'h1234);
    chk("irq_mret_mcause", mcause, 32'h8000_0003);

    // Sequential wrap-around.
    jump_to(32'hFFFF_FFFC);
    #1; chk("wrap_next", next_pc, 32'h0);
    chk("wrap_flush", {31'b0, flush}, 32'h0);
    step(); chk("wrap_pc", pc_out, 32'h0);

    // Reset wins over a concurrent trap.
    idle(); rst = 1; trap_req = 1; #1;
    chk("rst_trap_taken2", {31'b0, trap_taken}, 32'h0);
    step();
    chk("rst_trap_pc", pc_out, 32'h100);
    chk("rst_trap_epc", epc, 32'h0);
    chk("rst_trap_mcause", mcause, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the single-cycle RISC-V core. It owns the PC register, selects the next fetch address, and owns the trap-return state. It extends plain next-PC selection with:
- stall and hold;
- trap entry through a direct or vectored trap vector;
- automatic instruction-address-misaligned trap detection;
- an EPC/cause register pair with a CSR write port.

It sits between the ALU/branch logic and instruction memory, and feeds `epc` back to the CSR file.

## Interface
- `XLEN`, 32, datapath/address width.
- `RESET_VECTOR`, 32'h0000_0000, `pc_out` value after reset.
- `CAUSE_W`, 5, width of trap cause code.
- `VECTORED`, 0, 1 = interrupts enter at `mtvec_base + 4*cause`; 0 = all traps enter at `mtvec_base`.

Ports:
- `clk` in 1 system clock, rising edge.
- `rst` in 1 synchronous reset, active-high.
- `stall` in 1 hold PC this cycle.
- `br_taken` in 1 conditional branch taken.
- `j_en` in 1 jal/jalr.
- `addr_from_alu` in XLEN branch/jump target.
- `trap_req` in 1 external exception/interrupt request.
- `trap_irq` in 1 qualifies `trap_req` as interrupt.
- `trap_cause` in CAUSE_W cause code for `trap_req`.
- `mret` in 1 return from trap.
- `mtvec_base` in XLEN trap vector base; bits [1:0] ignored.
- `csr_epc_we` in 1 CSR write to EPC.
- `csr_epc_wdata` in XLEN CSR write data.
- `pc_out` out XLEN current PC (registered).
- `next_pc` out XLEN PC for next cycle (combinational).
- `epc` out XLEN exception PC (registered), bits [1:0] always 0.
- `mcause` out XLEN bit XLEN-1 = interrupt flag, low CAUSE_W bits = cause (registered).
- `flush` out 1 combinational; high when `next_pc` != `pc_out+4` for any reason other than stall.
- `trap_taken` out 1 combinational; high in any cycle a trap (external or misaligned) is taken.

## Operation
- Misaligned detect: `mis = (br_taken|j_en) & (addr_from_alu[1:0] != 0) & ~stall`.
- Next-PC priority, highest first:
  1. `rst`: `RESET_VECTOR`.
  2. `trap_req`: vector. Overrides `stall`.
  3. `mis`: `{mtvec_base[XLEN-1:2],2'b00}`, cause 0, exception.
  4. `stall`: `pc_out`. `br_taken`, `j_en` and `mret` are ignored.
  5. `mret`: `epc`.
  6. `br_taken|j_en`: `addr_from_alu`.
  7. Otherwise: `pc_out+4`, modulo 2^XLEN (wraps to 0).
- Vector for `trap_req`:
  - `VECTORED=1` and `trap_irq=1`: `{mtvec_base[XLEN-1:2],2'b00} + (trap_cause<<2)`, truncated to XLEN.
  - Otherwise: base only.
- EPC capture on a trap:
  - Exception (`trap_irq=0` or `mis`): `epc <= pc_out`.
  - Interrupt: `epc <= ` the value `next_pc` would have taken at priority levels 4–7. The current instruction retires; a pending `mret` therefore resolves to the old `epc`.
- `mcause` on a trap: `{trap_irq, 0..., trap_cause}`. For `mis`: 0.
- CSR writes:
  - `csr_epc_we` writes `{csr_epc_wdata[XLEN-1:2],2'b00}` only in cycles with no trap; trap capture wins.
  - `mret` does not modify `epc` or `mcause`.

## Timing
- All state updates on rising `clk`. Reset is synchronous: `pc_out`, `epc` and `mcause` take their reset values at the first edge with `rst=1`.
- Reset values: `pc_out=RESET_VECTOR`, `epc=0`, `mcause=0`.
- While `rst=1`: `next_pc=RESET_VECTOR`, `flush=0`, `trap_taken=0`. All other inputs are ignored.
- Redirect latency: `next_pc`/`flush` respond combinationally in the same cycle; `pc_out` reflects the redirect after one edge.
- `epc`/`mcause` update on the same edge that loads the trap vector into `pc_out`.
- Stall hold: `pc_out` is held for exactly as many cycles as `stall=1`.
- Stall release: a branch presented in the first unstalled cycle is honoured.
- `rst` asserted mid-stall or mid-trap: reset wins on that edge; no `epc` capture occurs.

## Test plan
- Reset and sequential, `RESET_VECTOR=32'h100`:
  - Stimulus: `rst` for 2 cycles, then release.
  - Required response: `pc_out` reads 100, 104, 108; `epc=0`; `flush=0`.
- Stall and branch interplay:
  - Stimulus: `pc=200`; `stall=1` with `br_taken=1`, target 300, for 3 cycles; then `stall=0`.
  - Required response: `pc_out` stays 200 for 3 cycles, then 300; `flush=1` only in the unstalled cycle.
- Vectored interrupt, `VECTORED=1`:
  - Stimulus: `mtvec_base=32'h1001`, `trap_irq=1`, `cause=7`, `pc=400`, `j_en=1`, target 500.
  - Required response: `next_pc=101C`; `epc=500`; `mcause=32'h8000_0007`.
- Misaligned jump:
  - Stimulus: `pc=40`, `j_en=1`, target 32'h42, `mtvec_base=800`.
  - Required response: `pc_out=800`; `epc=40`; `mcause=0`; `trap_taken=1`.
- Trap/CSR collision then mret:
  - Stimulus: `trap_req` (exception, cause 2) and `csr_epc_we` with `wdata=999` in the same cycle at `pc=60`; later `mret`.
  - Required response: `epc=60`, not the CSR data; `mret` returns `pc_out=60`.
- Wrap-around:
  - Stimulus: `pc=32'hFFFF_FFFC`, no redirect.
  - Required response: `pc_out=0`.
